// File: rtl/morse_receiver.sv
`timescale 1ns/1ps
// morse_receiver
//   Single-key Morse decoder for the letters A..H. The raw key passes through
//   a two-flop synchronizer. Press length, counted in time-unit ticks, picks
//   dot or dash. A release that lasts long enough ends the letter.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no letter in progress; waiting for a press
//   PRESS  | key held; counting ticks to tell dot from dash
//   GAP    | key released; counting ticks until the next press or letter end
//
// Ports
//   CLOCK50_i            system clock; all state changes on the rising edge
//   rst_ni               asynchronous active-low reset
//   tick_i               one-cycle strobe, once per time unit
//   key_ni               raw push button, 0 = pressed, asynchronous
//   letter_o [2:0]       last decoded letter index (0=A .. 7=H), 0 on error
//   code_o   [3:0]       last assembled pattern, right-aligned, dash = 1
//   len_o    [2:0]       symbol count of the last letter
//   valid_o              one-cycle pulse on a decoded letter
//   error_o              one-cycle pulse on a rejected letter
//   dotLed_o / dashLed_o live classification of the current press
//   busyLed_o            high whenever the FSM is not in IDLE
module morse_receiver #(
    parameter int DOT_MAX_TICKS = 1,
    parameter int GAP_TICKS     = 3
) (
    input  logic       CLOCK50_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       key_ni,
    output logic [2:0] letter_o,
    output logic [3:0] code_o,
    output logic [2:0] len_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       dotLed_o,
    output logic       dashLed_o,
    output logic       busyLed_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [2:0] DOT_MAX = 3'(DOT_MAX_TICKS);
    localparam logic [2:0] GAP_MAX = 3'(GAP_TICKS);
    localparam logic [2:0] CNT_SAT = 3'd7;

    logic       key_meta;
    logic       key_sync;
    logic       pressed;

    logic [1:0] state,  state_nx;
    logic [2:0] cnt,    cnt_nx;
    logic [3:0] shift,  shift_nx;
    logic [2:0] len,    len_nx;
    logic       ovf,    ovf_nx;
    logic       letter_end;
    logic       sym;

    logic       match;
    logic [2:0] idx;
    logic       accept;

    always_ff @(posedge CLOCK50_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_ni;
            key_sync <= key_meta;
        end
    end

    assign pressed = ~key_sync;

    // Pattern lookup on the assembled symbols.
    always_comb begin
        match = 1'b1;
        idx   = 3'd0;
        case ({len, shift})
            {3'd2, 4'b0001}: idx = 3'd0;
            {3'd4, 4'b1000}: idx = 3'd1;
            {3'd4, 4'b1010}: idx = 3'd2;
            {3'd3, 4'b0100}: idx = 3'd3;
            {3'd1, 4'b0000}: idx = 3'd4;
            {3'd4, 4'b0010}: idx = 3'd5;
            {3'd3, 4'b0110}: idx = 3'd6;
            {3'd4, 4'b0000}: idx = 3'd7;
            default:         match = 1'b0;
        endcase
    end

    assign accept = match & ~ovf;
    assign sym    = (cnt > DOT_MAX);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shift_nx   = shift;
        len_nx     = len;
        ovf_nx     = ovf;
        letter_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (pressed) begin
                    state_nx = S_PRESS;
                    cnt_nx   = 3'd0;
                    shift_nx = 4'd0;
                    len_nx   = 3'd0;
                    ovf_nx   = 1'b0;
                end
            end
            S_PRESS: begin
                // A release takes priority; a tick in the same cycle is dropped
                // so it cannot push a dot over into a dash.
                if (!pressed) begin
                    if (len == 3'd4) begin
                        ovf_nx = 1'b1;
                    end else begin
                        shift_nx = {shift[2:0], sym};
                        len_nx   = len + 3'd1;
                    end
                    cnt_nx   = 3'd0;
                    state_nx = S_GAP;
                end else if (tick_i && (cnt != CNT_SAT)) begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            S_GAP: begin
                if (cnt >= GAP_MAX) begin
                    letter_end = 1'b1;
                    cnt_nx     = 3'd0;
                    state_nx   = S_IDLE;
                end else if (pressed) begin
                    cnt_nx   = 3'd0;
                    state_nx = S_PRESS;
                end else if (tick_i && (cnt != CNT_SAT)) begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLOCK50_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            shift <= 4'd0;
            len   <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shift <= shift_nx;
            len   <= len_nx;
            ovf   <= ovf_nx;
        end
    end

    // Outputs are registered from next-state values so the LEDs track the
    // FSM register exactly, and the result pulses the cycle after letter end.
    always_ff @(posedge CLOCK50_i or negedge rst_ni) begin
        if (!rst_ni) begin
            letter_o  <= 3'd0;
            code_o    <= 4'd0;
            len_o     <= 3'd0;
            valid_o   <= 1'b0;
            error_o   <= 1'b0;
            dotLed_o  <= 1'b0;
            dashLed_o <= 1'b0;
            busyLed_o <= 1'b0;
        end else begin
            valid_o   <= letter_end &  accept;
            error_o   <= letter_end & ~accept;
            if (letter_end) begin
                letter_o <= accept ? idx : 3'd0;
                code_o   <= shift;
                len_o    <= ovf ? 3'd4 : len;
            end
            dotLed_o  <= (state_nx == S_PRESS) && (cnt_nx <= DOT_MAX);
            dashLed_o <= (state_nx == S_PRESS) && (cnt_nx >  DOT_MAX);
            busyLed_o <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_morse_receiver.sv
`timescale 1ns/1ps
module tb_morse_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       key;
    logic [2:0] letter_o;
    logic [3:0] code_o;
    logic [2:0] len_o;
    logic       valid_o;
    logic       error_o;
    logic       dotLed_o;
    logic       dashLed_o;
    logic       busyLed_o;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_error = 0;
    int n_both  = 0;

    always #10 clk = ~clk;

    morse_receiver #(.DOT_MAX_TICKS(1), .GAP_TICKS(3)) dut (
        .CLOCK50_i (clk),
        .rst_ni    (rst_n),
        .tick_i    (tick),
        .key_ni    (key),
        .letter_o  (letter_o),
        .code_o    (code_o),
        .len_o     (len_o),
        .valid_o   (valid_o),
        .error_o   (error_o),
        .dotLed_o  (dotLed_o),
        .dashLed_o (dashLed_o),
        .busyLed_o (busyLed_o)
    );

    always @(negedge clk) begin
        if (valid_o) n_valid++;
        if (error_o) n_error++;
        if (valid_o && error_o) n_both++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    // Press for n ticks then release; reports the LEDs just before release.
    task automatic press_sym(input int n, output logic dot_seen, output logic dash_seen);
        key = 1'b0;
        repeat (3) step();
        tick_pulses(n);
        dot_seen  = dotLed_o;
        dash_seen = dashLed_o;
        key = 1'b1;
        repeat (3) step();
    endtask

    task automatic wait_pulse(input string tag, output logic v, output logic e);
        logic found;
        found = 1'b0;
        v = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (valid_o || error_o) begin
                v = valid_o;
                e = error_o;
                found = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_seen"}, 8'(found), 8'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic d, s, v, e;
        int nv, ne;

        rst_n = 1'b0;
        tick  = 1'b0;
        key   = 1'b1;
        step();
        step();
        chk("reset_outs", 8'({letter_o, code_o, len_o, valid_o, error_o,
                               dotLed_o, dashLed_o, busyLed_o}), 8'd0);
        rst_n = 1'b1;
        step();

        // E: single dot
        press_sym(0, d, s);
        chk("e_dotled", 8'({d, s}), 8'b10);
        chk("e_busy_gap", 8'(busyLed_o), 8'd1);
        tick_pulses(3);
        wait_pulse("e", v, e);
        chk("e_ve", 8'({v, e}), 8'b10);
        chk("e_letter", 8'(letter_o), 8'd4);
        chk("e_code", 8'(code_o), 8'b0000);
        chk("e_len", 8'(len_o), 8'd1);
        step();
        chk("e_pulse_one_cycle", 8'({valid_o, error_o, busyLed_o}), 8'd0);

        // C: -.-.
        press_sym(3, d, s);
        chk("c_dash1_led", 8'({d, s}), 8'b01);
        tick_pulses(1);
        press_sym(0, d, s);
        chk("c_dot1_led", 8'({d, s}), 8'b10);
        tick_pulses(1);
        press_sym(3, d, s);
        chk("c_dash2_led", 8'({d, s}), 8'b01);
        tick_pulses(1);
        press_sym(0, d, s);
        tick_pulses(3);
        wait_pulse("c", v, e);
        chk("c_ve", 8'({v, e}), 8'b10);
        chk("c_letter", 8'(letter_o), 8'd2);
        chk("c_code", 8'(code_o), 8'b1010);
        chk("c_len", 8'(len_o), 8'd4);
        repeat (5) step();
        chk("c_hold", 8'({letter_o, code_o, len_o}), 8'({3'd2, 4'b1010, 3'd4}));

        // ---: unknown pattern
        press_sym(2, d, s);
        tick_pulses(1);
        press_sym(2, d, s);
        tick_pulses(1);
        press_sym(2, d, s);
        tick_pulses(3);
        wait_pulse("ooo", v, e);
        chk("ooo_ve", 8'({v, e}), 8'b01);
        chk("ooo_letter", 8'(letter_o), 8'd0);
        chk("ooo_code", 8'(code_o), 8'b0111);
        chk("ooo_len", 8'(len_o), 8'd3);

        // Five dots: overflow
        nv = n_valid;
        for (int i = 0; i < 5; i++) begin
            press_sym(0, d, s);
            if (i < 4) tick_pulses(1);
        end
        tick_pulses(3);
        wait_pulse("ovf", v, e);
        chk("ovf_ve", 8'({v, e}), 8'b01);
        chk("ovf_len", 8'(len_o), 8'd4);
        chk("ovf_letter", 8'(letter_o), 8'd0);
        step();
        chk("ovf_no_valid", 8'(n_valid - nv), 8'd0);

        // Release coincident with a tick at count 1, then a press coincident
        // with a GAP tick at count 2: expect A (.-).
        nv = n_valid;
        ne = n_error;
        key = 1'b0;
        repeat (3) step();
        tick_pulses(1);
        chk("coin_dotled_cnt1", 8'({dotLed_o, dashLed_o}), 8'b10);
        key = 1'b1;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("coin_release_gap", 8'({dotLed_o, dashLed_o, busyLed_o}), 8'b001);
        tick_pulses(2);
        key = 1'b0;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("coin_press_wins", 8'({dotLed_o, dashLed_o, busyLed_o}), 8'b101);
        tick_pulses(2);
        chk("coin_dashled", 8'({dotLed_o, dashLed_o}), 8'b01);
        key = 1'b1;
        repeat (3) step();
        tick_pulses(3);
        wait_pulse("coin", v, e);
        chk("coin_ve", 8'({v, e}), 8'b10);
        chk("coin_letter", 8'(letter_o), 8'd0);
        chk("coin_code", 8'(code_o), 8'b0001);
        chk("coin_len", 8'(len_o), 8'd2);
        step();
        chk("coin_pulse_count", 8'({4'(n_valid - nv), 4'(n_error - ne)}), 8'h10);

        // Reset mid-letter after two dots
        press_sym(0, d, s);
        tick_pulses(1);
        press_sym(0, d, s);
        nv = n_valid;
        ne = n_error;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 8'({valid_o, error_o, dotLed_o, dashLed_o, busyLed_o}), 8'd0);
        chk("rst_mid_result", 8'({letter_o, code_o}), 8'd0);
        chk("rst_mid_len", 8'(len_o), 8'd0);
        rst_n = 1'b1;
        step();
        tick_pulses(4);
        chk("rst_no_pulse", 8'({4'(n_valid - nv), 4'(n_error - ne)}), 8'h00);
        chk("rst_idle", 8'(busyLed_o), 8'd0);

        // D: -.. after reset
        press_sym(2, d, s);
        tick_pulses(1);
        press_sym(0, d, s);
        tick_pulses(1);
        press_sym(0, d, s);
        tick_pulses(3);
        wait_pulse("d", v, e);
        chk("d_ve", 8'({v, e}), 8'b10);
        chk("d_letter", 8'(letter_o), 8'd3);
        chk("d_code", 8'(code_o), 8'b0100);
        chk("d_len", 8'(len_o), 8'd3);

        step();
        chk("never_both", 8'(n_both), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 Parameter DOT_MAX_TICKS, default 1: maximum held ticks still classified as a dot.
REQ-002 Parameter GAP_TICKS, default 3: released ticks that terminate a letter.
REQ-003 CLOCK50_i  in  1  50 MHz system clock; sole clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 tick_i  in  1  one-cycle strobe, once per half-second time unit.
REQ-006 key_ni  in  1  raw push button, active-low (0 = pressed), asynchronous to the clock.
REQ-007 letter_o  out  3  last decoded letter index, 0=A .. 7=H.
REQ-008 code_o  out  4  last assembled symbol pattern, right-aligned, dash=1, first symbol most significant.
REQ-009 len_o  out  3  symbol count of the last letter, 0..4.
REQ-010 valid_o  out  1  one-cycle pulse when a letter is decoded successfully.
REQ-011 error_o  out  1  one-cycle pulse when a letter is rejected.
REQ-012 dotLed_o / dashLed_o  out  1 each  live classification of the current press.
REQ-013 busyLed_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 key_ni shall pass through a 2-flop synchronizer (flops reset to 1); "pressed" means synchronized key = 0. The FSM sees an edge 2 cycles after the pin.
REQ-015 The FSM shall have states IDLE, PRESS and GAP.
REQ-016 IDLE: on pressed -> PRESS with tick count = 0, shift register = 0, len = 0, overflow flag = 0.
REQ-017 PRESS: each tick_i increments a 3-bit tick count, saturating at 7.
REQ-018 PRESS: on release -> classify as dot if count <= DOT_MAX_TICKS, else as dash.
  - Shift the symbol in: code = {code[2:0], sym}; len = len + 1.
  - Clear the count and enter GAP.
REQ-019 A symbol classified while len = 4 shall not shift and shall not increment len; it shall set the overflow flag.
REQ-020 GAP: each tick_i increments the count, saturating. Pressed before the count reaches GAP_TICKS -> PRESS with count = 0, symbols retained.
REQ-021 GAP: the cycle the count reaches GAP_TICKS is the letter-end cycle. The next cycle shall pulse valid_o or error_o, update letter_o/code_o/len_o and enter IDLE.
REQ-022 Decode table (len, code): A(2,0001), B(4,1000), C(4,1010), D(3,0100), E(1,0000), F(4,0010), G(3,0110), H(4,0000).
REQ-023 A match shall pulse valid_o with letter_o = index. letter_o/code_o/len_o shall hold until the next letter end.
REQ-024 No match or overflow shall pulse error_o and set letter_o = 0. code_o/len_o shall still load the assembled values, with len_o = 4 on overflow.
REQ-025 valid_o and error_o shall never both be high.
REQ-026 Release and tick_i in the same cycle: the release is processed and the tick is discarded. Press and tick_i in the same GAP cycle: the press wins.
REQ-027 dotLed_o shall be 1 in PRESS with count <= DOT_MAX_TICKS. dashLed_o shall be 1 in PRESS with count > DOT_MAX_TICKS. Both shall be 0 otherwise.
REQ-028 All outputs shall be registered.

Reset
REQ-029 rst_ni low shall immediately force:
  - state = IDLE, synchronizer = 1, all counters and shift register = 0;
  - every output = 0.
REQ-030 Reset mid-letter shall discard partial symbols without emitting valid_o or error_o.
REQ-031 After rst_ni rises, a key already held shall be treated as a new press, taken up through the 2-flop synchronizer.

Verification
REQ-032 Press for 0 ticks, release, wait 3 ticks -> valid_o pulse, letter_o=4 (E), code_o=0000, len_o=1.
REQ-033 Press for 3 ticks, release 1 tick, press 0 ticks, release 1 tick, press 3 ticks, release 1 tick, press 0 ticks, release 3 ticks -> letter_o=2 (C), code_o=1010, len_o=4, dashLed_o high during the dash presses.
REQ-034 Press dash, dash, dash (---) then gap -> error_o pulse, letter_o=0, code_o=0111, len_o=3.
REQ-035 Five dots separated by 1-tick gaps, then gap -> error_o pulse, len_o=4, no valid_o.
REQ-036 Release coincident with tick_i when count=1 -> classified dot (count stays 1); tick_i on the same cycle as a GAP-state press -> returns to PRESS, no letter end.
REQ-037 Assert rst_ni low after two symbols, then release -> no pulse, all outputs 0, next letter decodes normally.
